// File: rtl/round_robin_arbitrado_tester_if.sv
// Bus between the queue FIFOs / schedule tables and the two-lane weighted round-robin arbiter.
interface round_robin_arbitrado_tester_if #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int MAX_WEIGHT     = 64,
  parameter int TABLE_SIZE     = 8
);
  localparam int SW = $clog2(QUEUE_QUANTITY);
  localparam int WW = $clog2(MAX_WEIGHT);

  logic                      enb;
  logic [TABLE_SIZE*WW-1:0]  pesos;
  logic [TABLE_SIZE*SW-1:0]  selecciones;
  logic [QUEUE_QUANTITY-1:0] buf_empty;
  logic [SW-1:0]             selector;
  logic                      selector_enb;
  logic [SW-1:0]             sint_selector;
  logic                      sint_selector_enb;

  modport master (
    output enb, pesos, selecciones, buf_empty,
    input  selector, selector_enb, sint_selector, sint_selector_enb
  );

  modport slave (
    input  enb, pesos, selecciones, buf_empty,
    output selector, selector_enb, sint_selector, sint_selector_enb
  );
endinterface

// File: rtl/round_robin_arbitrado_tester.sv
// Table-driven weighted round-robin arbiter with two independently coded lanes that must agree.
// Optional macro RR_LANE_CHECK_EN adds a sticky lane_mismatch output comparing both lanes.
module round_robin_arbitrado_tester #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int MAX_WEIGHT     = 64,
  parameter int BUF_WIDTH      = 3,
  parameter int TABLE_SIZE     = 8
) (
  input  logic clk,
  input  logic rst,
  round_robin_arbitrado_tester_if.slave bus
`ifdef RR_LANE_CHECK_EN
  ,
  output logic lane_mismatch
`endif
);
  localparam int SW = $clog2(QUEUE_QUANTITY);
  localparam int WW = $clog2(MAX_WEIGHT);
  localparam int PW = $clog2(TABLE_SIZE);
  localparam logic [PW-1:0] LAST_PTR = PW'(TABLE_SIZE - 1);

  // DATA_BITS and BUF_WIDTH describe the surrounding FIFOs; only sanity-checked here.
  if (DATA_BITS < 1 || BUF_WIDTH < 1 || TABLE_SIZE < 2 ||
      QUEUE_QUANTITY < 2 || MAX_WEIGHT < 2) begin : g_bad_cfg
    $error("round_robin_arbitrado_tester: unsupported parameter set");
  end

  // ---------------------------------------------------------------
  // Primary lane: direct indexed table lookup
  // ---------------------------------------------------------------
  logic [PW-1:0] ptr_a_q, ptr_a_d;
  logic [WW-1:0] cnt_a_q, cnt_a_d;
  logic [SW-1:0] sel_a_q, sel_a_d;
  logic          enb_a_q, enb_a_d;
  logic [SW-1:0] q_a;
  logic [WW-1:0] w_a;

  assign q_a = bus.selecciones[ptr_a_q*SW +: SW];
  assign w_a = bus.pesos[ptr_a_q*WW +: WW];

  always_comb begin
    ptr_a_d = ptr_a_q;
    cnt_a_d = cnt_a_q;
    sel_a_d = sel_a_q;
    enb_a_d = 1'b0;
    if (bus.enb) begin
      if (w_a == '0 || bus.buf_empty[q_a]) begin
        ptr_a_d = (ptr_a_q == LAST_PTR) ? '0 : ptr_a_q + 1'b1;
        cnt_a_d = '0;
      end else begin
        sel_a_d = q_a;
        enb_a_d = 1'b1;
        if (cnt_a_q == w_a - 1'b1) begin
          ptr_a_d = (ptr_a_q == LAST_PTR) ? '0 : ptr_a_q + 1'b1;
          cnt_a_d = '0;
        end else begin
          cnt_a_d = cnt_a_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_a_q <= '0;
      cnt_a_q <= '0;
      sel_a_q <= '0;
      enb_a_q <= 1'b0;
    end else begin
      ptr_a_q <= ptr_a_d;
      cnt_a_q <= cnt_a_d;
      sel_a_q <= sel_a_d;
      enb_a_q <= enb_a_d;
    end
  end

  // ---------------------------------------------------------------
  // Second lane: one-hot AND-OR table mux, terminal test as cnt+1==w
  // ---------------------------------------------------------------
  logic [PW-1:0]             ptr_b_q, ptr_b_d;
  logic [WW-1:0]             cnt_b_q, cnt_b_d;
  logic [SW-1:0]             sel_b_q, sel_b_d;
  logic                      enb_b_q, enb_b_d;
  logic [TABLE_SIZE-1:0]     hit_b;
  logic [WW-1:0]             w_ent_b [TABLE_SIZE];
  logic [SW-1:0]             q_ent_b [TABLE_SIZE];
  logic [QUEUE_QUANTITY-1:0] qhit_b;
  logic [WW-1:0]             w_b;
  logic [SW-1:0]             q_b;
  logic                      empty_b;
  logic                      skip_b;
  logic                      last_b;

  for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_entry
    assign hit_b[gi]   = (ptr_b_q == PW'(gi));
    assign w_ent_b[gi] = bus.pesos[gi*WW +: WW] & {WW{hit_b[gi]}};
    assign q_ent_b[gi] = bus.selecciones[gi*SW +: SW] & {SW{hit_b[gi]}};
  end

  always_comb begin
    w_b = '0;
    q_b = '0;
    for (int i = 0; i < TABLE_SIZE; i++) begin
      w_b = w_b | w_ent_b[i];
      q_b = q_b | q_ent_b[i];
    end
  end

  for (genvar gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_queue
    assign qhit_b[gi] = (q_b == SW'(gi)) & bus.buf_empty[gi];
  end

  assign empty_b = |qhit_b;
  assign skip_b  = (w_b == '0) | empty_b;
  assign last_b  = (({1'b0, cnt_b_q} + 1'b1) == {1'b0, w_b});

  always_comb begin
    ptr_b_d = ptr_b_q;
    cnt_b_d = cnt_b_q;
    sel_b_d = sel_b_q;
    enb_b_d = 1'b0;
    if (bus.enb) begin
      enb_b_d = ~skip_b;
      if (!skip_b) begin
        sel_b_d = q_b;
      end
      // A skipped entry and a finished entry both move on with a fresh slot count.
      if (skip_b || last_b) begin
        ptr_b_d = (ptr_b_q == LAST_PTR) ? '0 : ptr_b_q + 1'b1;
        cnt_b_d = '0;
      end else begin
        cnt_b_d = cnt_b_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_b_q <= '0;
      cnt_b_q <= '0;
      sel_b_q <= '0;
      enb_b_q <= 1'b0;
    end else begin
      ptr_b_q <= ptr_b_d;
      cnt_b_q <= cnt_b_d;
      sel_b_q <= sel_b_d;
      enb_b_q <= enb_b_d;
    end
  end

  assign bus.selector          = sel_a_q;
  assign bus.selector_enb      = enb_a_q;
  assign bus.sint_selector     = sel_b_q;
  assign bus.sint_selector_enb = enb_b_q;

`ifdef RR_LANE_CHECK_EN
  logic mism_q, mism_d;

  assign mism_d = mism_q | ({sel_a_q, enb_a_q} != {sel_b_q, enb_b_q});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mism_q <= 1'b0;
    end else begin
      mism_q <= mism_d;
    end
  end

  assign lane_mismatch = mism_q;
`endif

endmodule

// File: tb/tb_round_robin_arbitrado_tester.sv
// Scoreboard bench: expected grant streams are expanded from the schedule tables and compared per cycle.
module tb_round_robin_arbitrado_tester;
  localparam int QQ = 4;
  localparam int MW = 64;
  localparam int TS = 8;
  localparam int SW = 2;
  localparam int WW = 6;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  round_robin_arbitrado_tester_if #(.QUEUE_QUANTITY(QQ), .MAX_WEIGHT(MW), .TABLE_SIZE(TS)) bus ();

`ifdef RR_LANE_CHECK_EN
  logic lane_mismatch;
`endif

  round_robin_arbitrado_tester #(
    .QUEUE_QUANTITY(QQ), .DATA_BITS(8), .MAX_WEIGHT(MW), .BUF_WIDTH(3), .TABLE_SIZE(TS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RR_LANE_CHECK_EN
    ,
    .lane_mismatch(lane_mismatch)
`endif
  );

  typedef struct packed {
    logic [SW-1:0] sel;
    logic          enb;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [SW-1:0] last_sel;
  int            cfg_sel[TS];
  int            cfg_w[TS];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < TS; i++) begin
      bus.selecciones[i*SW +: SW] = SW'(cfg_sel[i]);
      bus.pesos[i*WW +: WW]       = WW'(cfg_w[i]);
    end
  endtask

  task automatic push_item(input logic [SW-1:0] s, input logic e);
    exp_t x;
    x.sel = s;
    x.enb = e;
    sb.push_back(x);
  endtask

  // Net effect of the schedule: entry i grants sel[i] for w[i] cycles, or one idle cycle if skipped.
  task automatic push_entries(input int first, input logic [QQ-1:0] empty_mask);
    for (int i = first; i < TS; i++) begin
      if (cfg_w[i] == 0 || empty_mask[cfg_sel[i]]) begin
        push_item(last_sel, 1'b0);
      end else begin
        for (int k = 0; k < cfg_w[i]; k++) push_item(SW'(cfg_sel[i]), 1'b1);
        last_sel = SW'(cfg_sel[i]);
      end
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      cyc++;
      e = sb.pop_front();
      $display("[%0d] %s exp sel=%0d enb=%0d got sel=%0d enb=%0d sint_sel=%0d sint_enb=%0d",
               cyc, tag, e.sel, e.enb, bus.selector, bus.selector_enb,
               bus.sint_selector, bus.sint_selector_enb);
      check({tag, ".selector"}, 8'(bus.selector), 8'(e.sel));
      check({tag, ".selector_enb"}, 8'(bus.selector_enb), 8'(e.enb));
      check({tag, ".sint_selector"}, 8'(bus.sint_selector), 8'(e.sel));
      check({tag, ".sint_selector_enb"}, 8'(bus.sint_selector_enb), 8'(e.enb));
    end
`ifdef RR_LANE_CHECK_EN
    check({tag, ".lane_mismatch"}, 8'(lane_mismatch), 8'h00);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".selector"}, 8'(bus.selector), 8'h00);
    check({tag, ".selector_enb"}, 8'(bus.selector_enb), 8'h00);
    check({tag, ".sint_selector"}, 8'(bus.sint_selector), 8'h00);
    check({tag, ".sint_selector_enb"}, 8'(bus.sint_selector_enb), 8'h00);
  endtask

  task automatic set_weighted();
    cfg_sel = '{3, 1, 2, 0, 1, 2, 0, 2};
    cfg_w   = '{6, 5, 7, 3, 1, 2, 3, 6};
    apply_cfg();
  endtask

  initial begin
    rst           = 1'b0;
    bus.enb       = 1'b1;
    bus.buf_empty = '0;
    last_sel      = '0;
    set_weighted();

    // Reset held 40 ns; sampled on falling edges.
    repeat (4) begin
      #10;
      $display("reset sample t=%0t sel=%0d enb=%0d", $time, bus.selector, bus.selector_enb);
      check_zero("reset");
    end
    rst = 1'b1;

    // Two full 33-cycle weighted periods.
    push_entries(0, '0);
    push_entries(0, '0);
    drain("weighted");

    // Reconfigure at an entry boundary: every weight 1.
    cfg_sel = '{3, 1, 2, 0, 1, 2, 2, 2};
    cfg_w   = '{1, 1, 1, 1, 1, 1, 1, 1};
    apply_cfg();
    push_entries(0, '0);
    push_entries(0, '0);
    drain("reconfig");

    // Queue 2 empty with the weighted table.
    set_weighted();
    bus.buf_empty = 4'b0100;
    push_entries(0, 4'b0100);
    push_entries(0, 4'b0100);
    drain("empty_skip");

    // Enable dropped for 5 cycles in the middle of entry 0.
    bus.buf_empty = '0;
    repeat (3) push_item(2'd3, 1'b1);
    drain("gate_pre");
    bus.enb = 1'b0;
    repeat (5) push_item(2'd3, 1'b0);
    drain("gate_off");
    bus.enb = 1'b1;
    repeat (3) push_item(2'd3, 1'b1);
    last_sel = 2'd3;
    push_entries(1, '0);
    drain("gate_resume");

    // Queue 3 drains after two grants of entry 0: remaining slots forfeited.
    repeat (2) push_item(2'd3, 1'b1);
    drain("midempty_pre");
    bus.buf_empty = 4'b1000;
    push_item(2'd3, 1'b0);
    drain("midempty_skip");
    bus.buf_empty = '0;
    push_entries(1, '0);
    drain("midempty_post");

    // Asynchronous reset mid-entry clears outputs before any clock edge.
    repeat (2) push_item(2'd3, 1'b1);
    drain("prereset");
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst      = 1'b1;
    last_sel = '0;
    repeat (6) push_item(2'd3, 1'b1);
    push_item(2'd1, 1'b1);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/round_robin_arbitrado_tester.md
Name: round_robin_arbitrado_tester

Overview:
- Table-driven weighted round-robin queue arbiter with two lanes in one block.
- The primary lane drives selector/selector_enb. A second, independently coded lane drives sint_selector/sint_selector_enb.
- Both lanes are fed identical inputs and must agree on every cycle.
- Sits between the per-queue FIFOs (empty flags) and the output mux that reads the granted queue.

Parameters:
- QUEUE_QUANTITY, 4: number of queues; selection width SW = $clog2(QUEUE_QUANTITY) = 2.
- DATA_BITS, 8: queue data width; reserved, no logic uses it.
- MAX_WEIGHT, 64: weight range; weight width WW = $clog2(MAX_WEIGHT) = 6.
- BUF_WIDTH, 3: FIFO address width; reserved, no logic uses it.
- TABLE_SIZE, 8: number of schedule table entries.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- enb  in  1  arbiter enable.
- pesos  in  TABLE_SIZE*WW  weight table; entry i = pesos[i*WW +: WW].
- selecciones  in  TABLE_SIZE*SW  queue table; entry i = selecciones[i*SW +: SW].
- buf_empty  in  QUEUE_QUANTITY  per-queue empty flag, 1 = empty.
- selector  out  SW  granted queue, primary lane.
- selector_enb  out  1  grant valid, primary lane.
- sint_selector  out  SW  granted queue, second lane.
- sint_selector_enb  out  1  grant valid, second lane.

Behaviour:
- State per lane:
  - entry pointer ptr, log2(TABLE_SIZE) bits;
  - slot counter cnt, WW bits;
  - registered outputs.
- Reset (rst=0, asynchronous): ptr=0, cnt=0, selector=0, selector_enb=0. Same for the sint_* outputs.
- enb=0: ptr and cnt hold; selector_enb=0 on the next edge; selector holds its last value.
- Tables and buf_empty are sampled combinationally from ptr every cycle. Table changes take effect the next time an entry is read; there is no shadow copy.
- On each edge with enb=1, let q = sel[ptr] and w = pesos[ptr]:
  - If w==0 or buf_empty[q]==1: selector_enb=0, ptr advances, cnt=0. One idle cycle per skipped entry; no multi-entry skip within one cycle.
  - Otherwise: selector=q, selector_enb=1.
    - If cnt==w-1: ptr advances, cnt=0.
    - Else: cnt=cnt+1.
- Net effect: entry i grants queue sel[i] for pesos[i] consecutive enabled cycles, then moves to entry i+1.
- ptr wraps from TABLE_SIZE-1 to 0.
- Latency: the grant for an entry appears one cycle after ptr points at it (registered outputs).
- Queue becoming empty mid-entry: the entry ends immediately, its remaining slots are forfeited and ptr advances.
- Both lanes are bit-identical on every cycle, including during and after reset.

Optional Feature:
- Macro RR_LANE_CHECK_EN.
- Defined: adds output port lane_mismatch (1 bit).
  - Sticky; set on any cycle where {selector, selector_enb} != {sint_selector, sint_selector_enb}.
  - Cleared only by reset.
- Undefined: port and compare logic are absent.

Test Plan:
- Reset: hold rst=0 for 40 ns with enb=1, no buf_empty bits set (all queues non-empty) -> all outputs 0, selector_enb=0.
- Weighted round: entries 0..7 (sel,weight) = (3,6) (1,5) (2,7) (0,3) (1,1) (2,2) (0,3) (2,6); release reset.
  - Expect selector runs 3×6, 1×5, 2×7, 0×3, 1×1, 2×2, 0×3, 2×6 with selector_enb=1 throughout.
  - 33-cycle period, repeating.
- Reconfigure mid-run: all weights 1, sels 3,1,2,0,1,2,2,2 -> one grant per entry, 8-cycle period 3,1,2,0,1,2,2,2.
- Empty skip: buf_empty=4'b0100 with the weighted round config -> entries targeting queue 2 each give one selector_enb=0 cycle; the other grants are unchanged.
- Enable gating: enb=0 for 5 cycles mid-entry -> selector_enb=0; the sequence resumes with the remaining slot count on enb=1.
- Lane equality: every scenario -> sint_selector==selector and sint_selector_enb==selector_enb on every cycle; with RR_LANE_CHECK_EN defined, lane_mismatch stays 0.
